// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/compare ops plus iterative
// shift-add multiply and restoring divide, one bit per clock.
module alu_seq #(
  parameter int unsigned WIDTH      = 16,
  parameter bit          CMP_SIGNED = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] Q_AC,
  input  logic [WIDTH-1:0] Q_DR,
  input  logic [WIDTH-1:0] IN_IR,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] ALU_Result,
  output logic [WIDTH-1:0] ALU_Hi,
  output logic [4:0]       FLAGS
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_ROL  = 4'h6;
  localparam logic [3:0] OP_ROR  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
  localparam logic [3:0] OP_NAND = 4'hC;
  localparam logic [3:0] OP_LT   = 4'hD;
  localparam logic [3:0] OP_GT   = 4'hE;
  localparam logic [3:0] OP_EQ   = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] rhi_q, rhi_d;
  logic [4:0]       flg_q, flg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [3:0]       opcode;
  logic [WIDTH:0]   add_w, sub_w;
  logic             cmp_lt, cmp_gt;
  logic [WIDTH-1:0] op_res;
  logic             op_c, op_v;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [WIDTH:0]   div_sh, div_df;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem, div_quo;

  logic             load;
  logic [WIDTH-1:0] fin_res, fin_hi;
  logic             fin_c, fin_v, fin_dz;

  // Operand bits below the opcode field carry no meaning for this block.
  logic unused_ir;
  assign unused_ir = ^IN_IR[WIDTH-5:0];

  assign opcode = IN_IR[WIDTH-1 -: 4];

  // Single-cycle result, evaluated straight from the inputs in IDLE.
  always_comb begin
    add_w  = {1'b0, Q_AC} + {1'b0, Q_DR};
    sub_w  = {1'b0, Q_AC} - {1'b0, Q_DR};
    if (CMP_SIGNED) begin
      cmp_lt = $signed(Q_AC) < $signed(Q_DR);
      cmp_gt = $signed(Q_AC) > $signed(Q_DR);
    end else begin
      cmp_lt = Q_AC < Q_DR;
      cmp_gt = Q_AC > Q_DR;
    end
    op_res = '0;
    op_c   = 1'b0;
    op_v   = 1'b0;
    case (opcode)
      OP_ADD: begin
        op_res = add_w[WIDTH-1:0];
        op_c   = add_w[WIDTH];
        op_v   = (Q_AC[WIDTH-1] == Q_DR[WIDTH-1]) && (add_w[WIDTH-1] != Q_AC[WIDTH-1]);
      end
      OP_SUB: begin
        op_res = sub_w[WIDTH-1:0];
        op_c   = sub_w[WIDTH];
        op_v   = (Q_AC[WIDTH-1] != Q_DR[WIDTH-1]) && (sub_w[WIDTH-1] != Q_AC[WIDTH-1]);
      end
      OP_SHL: begin
        op_res = {Q_AC[WIDTH-2:0], 1'b0};
        op_c   = Q_AC[WIDTH-1];
      end
      OP_SHR: begin
        op_res = {1'b0, Q_AC[WIDTH-1:1]};
        op_c   = Q_AC[0];
      end
      OP_ROL: begin
        op_res = {Q_AC[WIDTH-2:0], Q_AC[WIDTH-1]};
        op_c   = Q_AC[WIDTH-1];
      end
      OP_ROR: begin
        op_res = {Q_AC[0], Q_AC[WIDTH-1:1]};
        op_c   = Q_AC[0];
      end
      OP_AND:  op_res = Q_AC & Q_DR;
      OP_OR:   op_res = Q_AC | Q_DR;
      OP_XOR:  op_res = Q_AC ^ Q_DR;
      OP_NOR:  op_res = ~(Q_AC | Q_DR);
      OP_NAND: op_res = ~(Q_AC & Q_DR);
      OP_LT:   op_res = WIDTH'(cmp_lt);
      OP_GT:   op_res = WIDTH'(cmp_gt);
      OP_EQ:   op_res = WIDTH'(Q_AC == Q_DR);
      default: op_res = '0;
    endcase
  end

  // One multiply step ({hi,lo} shifts right) and one restoring-divide step
  // (remainder in hi, dividend/quotient shifting left through lo).
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
    div_sh  = {hi_q, lo_q[WIDTH-1]};
    div_df  = div_sh - {1'b0, b_q};
    div_ge  = ~div_df[WIDTH];
    div_rem = div_ge ? div_df[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_quo = {lo_q[WIDTH-2:0], div_ge};
  end

  // Next-state, datapath and result capture.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    rhi_d   = rhi_q;
    flg_d   = flg_q;
    load    = 1'b0;
    fin_res = '0;
    fin_hi  = '0;
    fin_c   = 1'b0;
    fin_v   = 1'b0;
    fin_dz  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          a_d   = Q_AC;
          b_d   = Q_DR;
          cnt_d = '0;
          if (opcode == OP_MUL) begin
            state_d = S_MUL;
            hi_d    = '0;
            lo_d    = Q_DR;
          end else if ((opcode == OP_DIV) && (Q_DR != '0)) begin
            state_d = S_DIV;
            hi_d    = '0;
            lo_d    = Q_AC;
          end else if (opcode == OP_DIV) begin
            state_d = S_DONE;
            load    = 1'b1;
            fin_res = '1;
            fin_hi  = Q_AC;
            fin_dz  = 1'b1;
          end else begin
            state_d = S_DONE;
            load    = 1'b1;
            fin_res = op_res;
            fin_c   = op_c;
            fin_v   = op_v;
          end
        end
      end
      S_MUL: begin
        hi_d  = mul_hi;
        lo_d  = mul_lo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
          load    = 1'b1;
          fin_res = mul_lo;
          fin_hi  = mul_hi;
          fin_v   = (mul_hi != '0);
        end
      end
      S_DIV: begin
        hi_d  = div_rem;
        lo_d  = div_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
          load    = 1'b1;
          fin_res = div_quo;
          fin_hi  = div_rem;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      res_d = fin_res;
      rhi_d = fin_hi;
      flg_d = {(fin_res == '0), fin_res[WIDTH-1], fin_c, fin_v, fin_dz};
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      rhi_q   <= '0;
      flg_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rhi_q   <= rhi_d;
      flg_q   <= flg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ALU_Result = res_q;
  assign ALU_Hi     = rhi_q;
  assign FLAGS      = flg_q;

endmodule
